conv_row_feeder: RTL and testbench

Producer side of the convolution row interface. Accepts a raster pixel stream with a valid/ready handshake and buffers it in three rotating line slots. For each output row it presents three zero-padded image rows (top/mid/bottom) to the multi-filter convolution layer, pulses `image_start`, then holds those rows stable until the layer reports `conv_done`. Next row's data loads while the layer is busy. It sits between the image source (DMA/testbench) and the conv layer.

---
 rtl/conv_row_feeder_pkg.sv | 22 ++
 rtl/conv_row_feeder_if.sv | 30 +++
 rtl/conv_line_slot.sv | 29 ++
 rtl/conv_row_feeder.sv | 142 ++++++++++++++
 tb/tb_conv_row_feeder.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_row_feeder_pkg.sv
// Shared definitions for the conv row feeder: controller state encoding and
// helpers for packing padded rows and rotating the three line-slot pointers.
package conv_row_feeder_pkg;

   localparam int DATA_WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_BUSY  = 2'd2
   } state_t;

   // Low bit of padded-row element j.
   function automatic int elem_lo(input int j, input int dw);
      return j * dw;
   endfunction

   function automatic logic [1:0] slot_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

endpackage

// File: rtl/conv_row_feeder_if.sv
// Pixel-stream and conv-row signals between the image source, the feeder
// and the convolution layer.
interface conv_row_feeder_if
   import conv_row_feeder_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int H          = 6,
   parameter int W          = 6
);
   logic                          in_valid;
   logic [DATA_WIDTH-1:0]         in_data;
   logic                          in_ready;
   logic [0:(W+2)*DATA_WIDTH-1]   image0;
   logic [0:(W+2)*DATA_WIDTH-1]   image1;
   logic [0:(W+2)*DATA_WIDTH-1]   image2;
   logic                          image_start;
   logic                          conv_done;
   logic [$clog2(H)-1:0]          row_idx;
   logic                          frame_done;

   modport slave (
      input  in_valid, in_data, conv_done,
      output in_ready, image0, image1, image2, image_start, row_idx, frame_done
   );

   modport master (
      output in_valid, in_data, conv_done,
      input  in_ready, image0, image1, image2, image_start, row_idx, frame_done
   );
endinterface

// File: rtl/conv_line_slot.sv
// One buffered image row: column-addressed write port, whole-row read port.
module conv_line_slot
   import conv_row_feeder_pkg::*;
#(
   parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter  int W          = 6,
   localparam int CW         = (W > 1) ? $clog2(W) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    we_i,
   input  logic [CW-1:0]           col_i,
   input  logic [DATA_WIDTH-1:0]   data_i,
   output logic [W*DATA_WIDTH-1:0] row_o
);
   logic [W*DATA_WIDTH-1:0] row_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row_q <= '0;
      end else begin
         for (int c = 0; c < W; c++) begin
            if (we_i && col_i == CW'(c)) row_q[c*DATA_WIDTH +: DATA_WIDTH] <= data_i;
         end
      end
   end

   assign row_o = row_q;
endmodule

// File: rtl/conv_row_feeder.sv
// Buffers a raster pixel stream in three rotating line slots and issues
// zero-padded top/mid/bottom rows to the conv layer, one output row at a time.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | waiting until the rows needed for output row S are buffered
//   ST_START | image0..2 freshly loaded, image_start asserted this cycle
//   ST_BUSY  | conv layer working on the held rows, waiting for conv_done
module conv_row_feeder
   import conv_row_feeder_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int H          = 6,
   parameter int W          = 6
) (
   input logic              clk,
   input logic              reset,
   conv_row_feeder_if.slave bus
);
   localparam int RW  = $clog2(H + 1) + 1;
   localparam int RIW = $clog2(H);
   localparam int CW  = (W > 1) ? $clog2(W) : 1;
   localparam int RB  = (W + 2) * DATA_WIDTH;
   localparam int SB  = W * DATA_WIDTH;

   localparam logic [RW-1:0]  H_R      = RW'(H);
   localparam logic [CW-1:0]  LAST_COL = CW'(W - 1);
   localparam logic [RIW-1:0] LAST_ROW = RIW'(H - 1);

   state_t           state_q;
   logic [RW-1:0]    rows_in_q, s_q, need;
   logic [CW-1:0]    col_q;
   logic [1:0]       wptr_q, rptr_q;
   logic [RIW-1:0]   row_idx_q;
   logic             image_start_q, frame_done_q;
   logic [0:RB-1]    image0_q, image1_q, image2_q;
   logic [SB-1:0]    slot_row [3];
   logic [0:RB-1]    pad_row  [3];
   logic             in_ready, accept, start_go, frame_clear;

   always_comb begin
      in_ready    = !reset && (rows_in_q < H_R) && (rows_in_q <= s_q + RW'(1));
      accept      = bus.in_valid && in_ready;
      need        = (s_q + RW'(2) < H_R) ? s_q + RW'(2) : H_R;
      start_go    = (s_q < H_R) && (rows_in_q >= need);
      frame_clear = (state_q == ST_BUSY) && bus.conv_done && (row_idx_q == LAST_ROW);
   end

   for (genvar g = 0; g < 3; g++) begin : g_slot
      conv_line_slot #(.DATA_WIDTH(DATA_WIDTH), .W(W)) u_slot (
         .clk    (clk),
         .reset  (reset),
         .we_i   (accept && (wptr_q == 2'(g))),
         .col_i  (col_q),
         .data_i (bus.in_data),
         .row_o  (slot_row[g])
      );
   end

   // Border elements 0 and W+1 stay zero.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         pad_row[i] = '0;
         for (int c = 0; c < W; c++) begin
            pad_row[i][elem_lo(c + 1, DATA_WIDTH) +: DATA_WIDTH] =
               slot_row[i][c*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rows_in_q <= '0;
         col_q     <= '0;
         wptr_q    <= 2'd0;
      end else if (frame_clear) begin
         rows_in_q <= '0;
         col_q     <= '0;
         wptr_q    <= 2'd0;
      end else if (accept) begin
         if (col_q == LAST_COL) begin
            col_q     <= '0;
            rows_in_q <= rows_in_q + RW'(1);
            wptr_q    <= slot_inc(wptr_q);
         end else begin
            col_q <= col_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         s_q           <= '0;
         rptr_q        <= 2'd0;
         row_idx_q     <= '0;
         image_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
         image0_q      <= '0;
         image1_q      <= '0;
         image2_q      <= '0;
      end else begin
         image_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_go) begin
                  state_q       <= ST_START;
                  image_start_q <= 1'b1;
                  // rptr_q is the slot of row S; S-1 and S+1 sit one step either side.
                  image0_q  <= (s_q == '0) ? '0 : pad_row[slot_inc(slot_inc(rptr_q))];
                  image1_q  <= pad_row[rptr_q];
                  image2_q  <= (s_q + RW'(1) < H_R) ? pad_row[slot_inc(rptr_q)] : '0;
                  row_idx_q <= s_q[RIW-1:0];
                  s_q       <= s_q + RW'(1);
                  rptr_q    <= slot_inc(rptr_q);
               end
            end
            ST_START: state_q <= ST_BUSY;
            ST_BUSY: begin
               if (bus.conv_done) begin
                  state_q <= ST_IDLE;
                  if (frame_clear) begin
                     frame_done_q <= 1'b1;
                     s_q          <= '0;
                     rptr_q       <= 2'd0;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.image0      = image0_q;
   assign bus.image1      = image1_q;
   assign bus.image2      = image2_q;
   assign bus.image_start = image_start_q;
   assign bus.row_idx     = row_idx_q;
   assign bus.frame_done  = frame_done_q;
endmodule

// File: tb/tb_conv_row_feeder.sv
// Scoreboard bench for conv_row_feeder: expected row triples are queued as
// frames are streamed and checked whenever image_start is seen.
module tb_conv_row_feeder;
   localparam int DW  = 8;
   localparam int H   = 6;
   localparam int W   = 6;
   localparam int RB  = (W + 2) * DW;
   localparam int RIW = $clog2(H);
   localparam int BUDGET = 1000;

   typedef struct packed {
      logic [RIW-1:0] ri;
      logic [0:RB-1]  i0;
      logic [0:RB-1]  i1;
      logic [0:RB-1]  i2;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   conv_row_feeder_if #(.DATA_WIDTH(DW), .H(H), .W(W)) bus ();

   conv_row_feeder #(.DATA_WIDTH(DW), .H(H), .W(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int   vec_cnt = 0;
   int   miss_cnt = 0;
   int   cyc = 0;
   int   start_cnt = 0;
   int   fd_cnt = 0;
   int   fd_gap = 0;
   int   last_start = 0;
   exp_t sb [$];
   exp_t held;

   int   resp_mode = 0;   // 0: manual, 1: pulse after resp_delay, 2: held high
   int   resp_delay = 0;
   logic man_done = 1'b0;

   function automatic logic [0:RB-1] exp_row(input int r);
      logic [0:RB-1] v;
      v = '0;
      if (r >= 0 && r < H)
         for (int c = 0; c < W; c++) v[(c+1)*DW +: DW] = DW'(10*r + c + 1);
      return v;
   endfunction

   function automatic exp_t exp_out(input int r);
      exp_t e;
      e.ri = RIW'(r);
      e.i0 = exp_row(r - 1);
      e.i1 = exp_row(r);
      e.i2 = exp_row(r + 1);
      return e;
   endfunction

   task automatic chk(input string nm, input logic [RB-1:0] act, input logic [RB-1:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic bound_fail(input string nm);
      vec_cnt++;
      miss_cnt++;
      $display("FAIL %s: wait bound of %0d cycles expired (t=%0t)", nm, BUDGET, $time);
   endtask

   // Monitor: samples on the falling edge, away from DUT updates.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            chk("rst_image0", bus.image0, '0);
            chk("rst_image1", bus.image1, '0);
            chk("rst_image2", bus.image2, '0);
            chk("rst_image_start", RB'(bus.image_start), '0);
            chk("rst_frame_done", RB'(bus.frame_done), '0);
            chk("rst_row_idx", RB'(bus.row_idx), '0);
            chk("rst_in_ready", RB'(bus.in_ready), '0);
            sb.delete();
            held = '0;
         end else begin
            if (bus.image_start) begin
               start_cnt++;
               last_start = cyc;
               if (sb.size() == 0) begin
                  bound_fail("unexpected_image_start");
               end else begin
                  e = sb.pop_front();
                  chk("row_idx", RB'(bus.row_idx), RB'(e.ri));
                  chk("image0", bus.image0, e.i0);
                  chk("image1", bus.image1, e.i1);
                  chk("image2", bus.image2, e.i2);
                  held = e;
               end
            end else begin
               chk("hold_row_idx", RB'(bus.row_idx), RB'(held.ri));
               chk("hold_image0", bus.image0, held.i0);
               chk("hold_image1", bus.image1, held.i1);
               chk("hold_image2", bus.image2, held.i2);
            end
            if (bus.frame_done) begin
               fd_cnt++;
               fd_gap = cyc - last_start;
            end
         end
      end
   end

   // Conv-layer model, sole driver of conv_done.
   initial begin
      int cnt;
      cnt = 0;
      bus.conv_done = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         case (resp_mode)
            1: begin
               bus.conv_done = 1'b0;
               if (bus.image_start) cnt = resp_delay + 1;
               else if (cnt > 0) begin
                  cnt--;
                  if (cnt == 0) bus.conv_done = 1'b1;
               end
            end
            2: begin cnt = 0; bus.conv_done = 1'b1; end
            default: begin cnt = 0; bus.conv_done = man_done; end
         endcase
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic send_px(input int r, input int c);
      int k;
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(10*r + c + 1);
      k = 0;
      while (!bus.in_ready && k < BUDGET) begin tick(); k++; end
      if (!bus.in_ready) begin
         bound_fail($sformatf("pixel_accept_r%0d_c%0d", r, c));
         bus.in_valid = 1'b0;
      end else begin
         tick();
         bus.in_valid = 1'b0;
      end
   endtask

   task automatic send_row(input int r);
      for (int c = 0; c < W; c++) send_px(r, c);
   endtask

   task automatic push_frame();
      for (int r = 0; r < H; r++) sb.push_back(exp_out(r));
   endtask

   task automatic wait_fd(input int target);
      int k;
      k = 0;
      while (fd_cnt < target && k < BUDGET) begin tick(); k++; end
      if (fd_cnt < target) bound_fail("frame_done_wait");
      chk("frame_done_count", RB'(fd_cnt), RB'(target));
   endtask

   initial begin
      int k;
      int fd_before;
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      repeat (3) tick();
      reset = 1'b0;
      #1;
      chk("ready_after_reset", RB'(bus.in_ready), RB'(1));

      // Frame 1: manual conv_done for rows 0 and 1, then automatic with delay.
      push_frame();
      send_row(0);
      send_row(1);
      chk("start_latency_t", RB'(bus.image_start), '0);
      tick();
      chk("start_latency_t1", RB'(bus.image_start), RB'(1));
      send_row(2);
      for (int i = 0; i < 3; i++) begin
         chk("ready_low_busy", RB'(bus.in_ready), '0);
         tick();
      end
      man_done = 1'b1;
      tick();
      man_done   = 1'b0;
      resp_delay = 2;
      resp_mode  = 1;
      for (int r = 3; r < H; r++) send_row(r);
      wait_fd(1);
      chk("frame_done_gap_delay2", RB'(fd_gap), RB'(4));
      chk("starts_frame1", RB'(start_cnt), RB'(6));
      chk("ready_after_clear", RB'(bus.in_ready), RB'(1));

      // Frame 2: conv_done held high in IDLE and START.
      resp_mode = 2;
      push_frame();
      for (int r = 0; r < H; r++) send_row(r);
      wait_fd(2);
      chk("frame_done_gap_held", RB'(fd_gap), RB'(2));
      chk("starts_frame2", RB'(start_cnt), RB'(12));

      // Frame 3: reset during BUSY of row 3.
      resp_mode  = 1;
      resp_delay = 20;
      push_frame();
      for (int r = 0; r < 5; r++) send_row(r);
      k = 0;
      while (start_cnt < 16 && k < BUDGET) begin tick(); k++; end
      chk("starts_before_abort", RB'(start_cnt), RB'(16));
      tick();
      fd_before = fd_cnt;
      reset     = 1'b1;
      resp_mode = 0;
      repeat (2) tick();
      reset = 1'b0;
      #1;
      chk("ready_after_abort", RB'(bus.in_ready), RB'(1));
      repeat (5) tick();
      chk("no_frame_done_on_abort", RB'(fd_cnt), RB'(fd_before));

      // Frame 4: fresh frame after abort.
      resp_delay = 0;
      resp_mode  = 1;
      push_frame();
      for (int r = 0; r < H; r++) send_row(r);
      wait_fd(fd_before + 1);
      chk("starts_frame4", RB'(start_cnt), RB'(22));
      repeat (3) tick();
      chk("scoreboard_drained", RB'(sb.size()), '0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end
endmodule
